// File: rtl/spi_dac_if.sv
// SPI pin bundle plus decoded register-write and frame-status outputs.
// No latency of its own; pure signal grouping.
// No backpressure: the write port is a fire-and-forget pulse.
interface spi_dac_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              cs;
    logic              sclk;
    logic              da_sdi;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic              frame_err;
    logic [7:0]        word_cnt;
    logic              busy;

    // The decoder receives the SPI pins and drives the write port.
    modport slave (
        input  cs, sclk, da_sdi,
        output wr_en, wr_addr, wr_data, frame_done, frame_err, word_cnt, busy
    );

    // The SPI controller drives the pins and observes the write port.
    modport master (
        output cs, sclk, da_sdi,
        input  wr_en, wr_addr, wr_data, frame_done, frame_err, word_cnt, busy
    );
endinterface

// File: rtl/spi_dac_slave.sv
// SPI slave: decodes [addr][word][word]... frames into register-write pulses.
// Latency: wr_en on the 3rd clk rising edge after the sclk pin falling edge carrying the last bit.
// No backpressure: every completed word produces a one-cycle wr_en; the consumer must accept it.
module spi_dac_slave #(
    parameter int ADDR_W = 8,   // must not exceed DATA_W (address is assembled in the data shifter)
    parameter int DATA_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_dac_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Synchronizers and edge-detect history.
    logic             r_cs_s1, r_cs_s2;
    logic             r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic             r_sdi_s1, r_sdi_s2;
    logic [1:0]       r_live;   // becomes 2'b11 once the synchronizers hold real pin values
    logic             r_cs_d;   // previous synchronized cs, forced low until r_live settles

    // Frame decoder state.
    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_W-2:0]   r_shift, w_shift_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [7:0]          r_word_cnt, w_word_cnt_nxt;
    logic                r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;

    logic                w_cs_fall;
    logic                w_sclk_fall;
    logic [DATA_W-1:0]   w_word;

    // A cs falling edge is only believed once the synchronizer has shown cs high after reset,
    // so a reset released mid-frame waits for the next real frame start.
    assign w_cs_fall   = r_cs_d & ~r_cs_s2;
    // sclk edges are discarded whenever synchronized cs is high, including the same cycle.
    assign w_sclk_fall = r_sclk_d & ~r_sclk_s2 & ~r_cs_s2;
    // Word as it will look once the bit sampled this cycle is shifted in.
    assign w_word      = {r_shift, r_sdi_s2};

    // Two-flop synchronizers (equal depth for all pins) and edge-detect delay registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_sdi_s1  <= 1'b0;
            r_sdi_s2  <= 1'b0;
            r_live    <= 2'b00;
            r_cs_d    <= 1'b0;
        end else begin
            r_cs_s1   <= bus.cs;
            r_cs_s2   <= r_cs_s1;
            r_sclk_s1 <= bus.sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_sdi_s1  <= bus.da_sdi;
            r_sdi_s2  <= r_sdi_s1;
            r_live    <= {r_live[0], 1'b1};
            r_cs_d    <= r_live[1] ? r_cs_s2 : 1'b0;
        end
    end

    // Decoder state register and write/status output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_addr     <= w_addr_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Next-state and datapath: address phase, then repeated data words until cs rises.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_addr_nxt     = r_addr;
        w_word_cnt_nxt = r_word_cnt;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt    = S_ADDR;
                    w_bit_cnt_nxt  = '0;
                    w_shift_nxt    = '0;
                    w_word_cnt_nxt = '0;
                end
            end

            S_ADDR: begin
                if (r_cs_s2) begin
                    // Frame ended before the address was complete.
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (w_sclk_fall) begin
                    w_shift_nxt = w_word[DATA_W-2:0];
                    if (r_bit_cnt == ADDR_LAST) begin
                        w_addr_nxt    = w_word[ADDR_W-1:0];
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_DATA;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end

            S_DATA: begin
                if (r_cs_s2) begin
                    // Clean end only on a word boundary with at least one word written.
                    w_state_nxt = S_IDLE;
                    if ((r_bit_cnt == '0) && (r_word_cnt != 8'd0)) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt  = 1'b1;
                    end
                end else if (w_sclk_fall) begin
                    w_shift_nxt = w_word[DATA_W-2:0];
                    if (r_bit_cnt == DATA_LAST) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_addr;
                        w_wr_data_nxt = w_word;
                        w_addr_nxt    = r_addr + ADDR_W'(1);
                        w_bit_cnt_nxt = '0;
                        if (r_word_cnt != 8'hFF) begin
                            w_word_cnt_nxt = r_word_cnt + 8'd1;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.frame_done = r_done;
    assign bus.frame_err  = r_err;
    assign bus.word_cnt   = r_word_cnt;
    assign bus.busy       = ~r_cs_s2;

endmodule

// File: tb/tb_spi_dac_slave.sv
// Testbench for spi_dac_slave: directed SPI frames, scoreboard of expected writes and frame events.
// Expected values are pushed by the stimulus; an independent monitor pops them on each output pulse.
// Stimulus runs sclk at clk/6 with data changing on sclk rising and held across the falling edge.
module tb_spi_dac_slave;
    logic clk;
    logic rst_n;

    spi_dac_if #(.ADDR_W(8), .DATA_W(16)) u_if ();

    spi_dac_slave #(.ADDR_W(8), .DATA_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] exp_wr[$];   // {addr, data}
    logic [8:0]  exp_ev[$];   // {is_err, word_cnt}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: pulse with nothing expected at %0t", name, $time);
    endtask

    // Monitor: compares every write and frame-status pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.wr_en) begin
                if (exp_wr.size() == 0) begin
                    unexpected("wr_en");
                end else begin
                    logic [23:0] e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(u_if.wr_addr), 32'(e[23:16]));
                    chk("wr_data", 32'(u_if.wr_data), 32'(e[15:0]));
                end
            end
            if (u_if.frame_done && u_if.frame_err) begin
                unexpected("done_and_err_together");
            end else if (u_if.frame_done || u_if.frame_err) begin
                if (exp_ev.size() == 0) begin
                    unexpected(u_if.frame_err ? "frame_err" : "frame_done");
                end else begin
                    logic [8:0] e;
                    e = exp_ev.pop_front();
                    chk("frame_is_err", 32'(u_if.frame_err), 32'(e[8]));
                    chk("word_cnt_at_end", 32'(u_if.word_cnt), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic cs_low();
        u_if.cs = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_in_frame", 32'(u_if.busy), 32'd1);
    endtask

    task automatic cs_high();
        repeat (5) @(negedge clk);
        u_if.cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Send the low n bits of v, MSB first; one sclk period = 6 clk.
    task automatic shift_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            u_if.da_sdi = v[i];
            u_if.sclk   = 1'b1;
            repeat (3) @(negedge clk);
            u_if.sclk   = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"},      32'(u_if.wr_en),      32'd0);
        chk({tag, "_wr_addr"},    32'(u_if.wr_addr),    32'd0);
        chk({tag, "_wr_data"},    32'(u_if.wr_data),    32'd0);
        chk({tag, "_frame_done"}, 32'(u_if.frame_done), 32'd0);
        chk({tag, "_frame_err"},  32'(u_if.frame_err),  32'd0);
        chk({tag, "_word_cnt"},   32'(u_if.word_cnt),   32'd0);
        chk({tag, "_busy"},       32'(u_if.busy),       32'd0);
    endtask

    logic [15:0] burst_words [8] = '{16'hFF00, 16'hFFFF, 16'h0FFF, 16'hF00F,
                                     16'hFF00, 16'hFF00, 16'hFF00, 16'hF00F};
    logic [15:0] wrap_words  [3] = '{16'h1111, 16'h2222, 16'h3333};

    initial begin
        rst_n       = 1'b0;
        u_if.cs     = 1'b1;
        u_if.sclk   = 1'b0;
        u_if.da_sdi = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_busy", 32'(u_if.busy), 32'd0);

        // 24-bit config frame 0x030A2C.
        exp_wr.push_back({8'h03, 16'h0A2C});
        exp_ev.push_back({1'b0, 8'd1});
        cs_low();
        shift_bits(16'h0003, 8);
        shift_bits(16'h0A2C, 16);
        cs_high();
        chk("cfg_word_cnt", 32'(u_if.word_cnt), 32'd1);
        chk("cfg_wr_data_held", 32'(u_if.wr_data), 32'h0A2C);

        // Burst at 0x14, eight words.
        for (int i = 0; i < 8; i++) exp_wr.push_back({8'(8'h14 + i), burst_words[i]});
        exp_ev.push_back({1'b0, 8'd8});
        cs_low();
        shift_bits(16'h0014, 8);
        for (int i = 0; i < 8; i++) shift_bits(burst_words[i], 16);
        cs_high();
        chk("burst_word_cnt", 32'(u_if.word_cnt), 32'd8);

        // Address wrap 0xFE -> 0xFF -> 0x00.
        exp_wr.push_back({8'hFE, 16'h1111});
        exp_wr.push_back({8'hFF, 16'h2222});
        exp_wr.push_back({8'h00, 16'h3333});
        exp_ev.push_back({1'b0, 8'd3});
        cs_low();
        shift_bits(16'h00FE, 8);
        for (int i = 0; i < 3; i++) shift_bits(wrap_words[i], 16);
        cs_high();

        // Truncated data word: 9 bits then cs high.
        exp_ev.push_back({1'b1, 8'd0});
        cs_low();
        shift_bits(16'h0010, 8);
        shift_bits(16'h01A5, 9);
        cs_high();

        // Recovery frame 0x20 / 0xBEEF.
        exp_wr.push_back({8'h20, 16'hBEEF});
        exp_ev.push_back({1'b0, 8'd1});
        cs_low();
        shift_bits(16'h0020, 8);
        shift_bits(16'hBEEF, 16);
        cs_high();

        // Frame ending inside the address phase.
        exp_ev.push_back({1'b1, 8'd0});
        cs_low();
        shift_bits(16'h0015, 5);
        cs_high();

        // Address only, no data word.
        exp_ev.push_back({1'b1, 8'd0});
        cs_low();
        shift_bits(16'h0033, 8);
        cs_high();

        // Reset after 12 bits; remainder of that frame must be ignored.
        cs_low();
        shift_bits(16'h0055, 8);
        shift_bits(16'h000A, 4);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        shift_bits(16'h0ABC, 12);
        cs_high();
        exp_wr.push_back({8'h05, 16'h1234});
        exp_ev.push_back({1'b0, 8'd1});
        cs_low();
        shift_bits(16'h0005, 8);
        shift_bits(16'h1234, 16);
        cs_high();

        // 32 sclk cycles with cs held high: nothing may happen.
        for (int i = 0; i < 32; i++) begin
            shift_bits(16'(i[0] ? 16'hFFFF : 16'h0000), 1);
        end
        chk("cs_high_busy", 32'(u_if.busy), 32'd0);
        repeat (6) @(negedge clk);

        chk("writes_outstanding", 32'(exp_wr.size()), 32'd0);
        chk("events_outstanding", 32'(exp_ev.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_dac_slave.md
SPI_DAC_SLAVE -- requirements
Module: spi_dac_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address field width in bits.
REQ-002 SHALL have parameter DATA_W, default 16, data word width in bits.
REQ-003 SHALL have port clk  input  1  system clock (100 MHz); all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port sclk  input  1  SPI serial clock, idles low, asynchronous to clk.
REQ-007 SHALL have port da_sdi  input  1  serial data from master, MSB first.
REQ-008 SHALL have port wr_en  output  1  one-cycle pulse per received data word.
REQ-009 SHALL have port wr_addr  output  ADDR_W  register address for the current wr_en.
REQ-010 SHALL have port wr_data  output  DATA_W  data word for the current wr_en.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when a well-formed frame ends.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse when a frame ends malformed.
REQ-013 SHALL have port word_cnt  output  8  count of words written in the current or most recent frame.
REQ-014 SHALL have port busy  output  1  high while synchronized cs is low.

Function
REQ-015 SHALL pass cs, sclk and da_sdi each through a two-flop synchronizer of equal depth, then one delay register on sclk for edge detection.
REQ-016 SHALL treat sclk falling edge (synchronized 1->0) as the sample point; da_sdi is shifted in on that edge, MSB first.
REQ-017 SHALL support sclk with each phase >= 3 clk cycles (sclk <= clk/6).
REQ-018 SHALL ignore all sclk edges while synchronized cs is high, including an edge detected in the same cycle that cs is seen high.
REQ-019 SHALL implement states IDLE, ADDR, DATA.
REQ-020 IDLE -> ADDR on synchronized cs falling; bit counter cleared, word_cnt cleared.
REQ-021 ADDR: after ADDR_W sampled bits, load address register, clear bit counter, -> DATA.
REQ-022 DATA: after each DATA_W sampled bits, pulse wr_en for one clk with wr_addr = address register and wr_data = assembled word; then increment address register and word_cnt; remain in DATA.
REQ-023 Address increment SHALL wrap modulo 2^ADDR_W (0xFF -> 0x00); word_cnt SHALL saturate at 255.
REQ-024 wr_en SHALL assert on the 3rd clk rising edge after the sclk pin falling edge carrying the last bit of the word (pin setup met); wr_addr/wr_data SHALL hold until the next wr_en.
REQ-025 Any state -> IDLE on synchronized cs rising, within the same cycle-count latency.
REQ-026 On cs rising in DATA with bit counter 0 and word_cnt >= 1: pulse frame_done.
REQ-027 On cs rising in ADDR, or in DATA with bit counter != 0, or in DATA with word_cnt = 0: pulse frame_err, discard partial bits, no wr_en.
REQ-028 frame_done and frame_err SHALL never assert in the same cycle.
REQ-029 A 24-bit frame (8 addr + 16 data) SHALL be decoded identically to a burst of length 1.

Reset
REQ-030 SHALL on rst_n low immediately set state IDLE, all synchronizers to cs=1/sclk=0/sdi=0, and wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_err=0, word_cnt=0, busy=0.
REQ-031 SHALL, after rst_n release while cs pin is low mid-frame, stay in IDLE until the next cs falling edge (no partial-frame decode).

Verification
REQ-032 Config frame 0x030A2C (24 bits, sclk = clk/6) -> one wr_en, wr_addr=0x03, wr_data=0x0A2C; frame_done pulse; word_cnt=1; frame_err=0.
REQ-033 Burst addr 0x14 + 8 words {0xFF00,0xFFFF,0x0FFF,0xF00F,0xFF00,0xFF00,0xFF00,0xF00F} -> 8 wr_en at addrs 0x14..0x1B with matching data in order; word_cnt=8; frame_done pulse.
REQ-034 Addr 0xFE + 3 words -> wr_addr sequence 0xFE, 0xFF, 0x00.
REQ-035 Addr 0x10 + 9 data bits then cs high -> no wr_en, frame_err pulse, frame_done=0; next frame addr 0x20 + 1 word decodes correctly.
REQ-036 rst_n low after 12 bits of a frame -> all outputs 0; cs released and reasserted, addr 0x05 + word 0x1234 -> single write 0x05/0x1234.
REQ-037 32 sclk cycles with cs held high -> no wr_en, no frame_done, no frame_err, busy=0.
